// File: rtl/mult_pipe_unit.sv
// Four-stage pipelined signed WIDTHxWIDTH multiplier that sits beside execute.
// Carries each instruction word down the pipe for the multiply-stall logic.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   in_valid/in_*         issued multiply: instruction word and signed operands
//   hold, flush           freeze every stage / kill every in-flight op
//   instruction_1..4      instruction word per stage, BUBBLE when empty
//   stage_valid           per-stage occupancy, bit k-1 = stage k
//   mult_ins_signal       any stage occupied
//   out_valid/out_*       stage 4 result: low product bits, overflow, instruction
module mult_pipe_unit #(
    parameter int          WIDTH  = 32,
    parameter logic [31:0] BUBBLE = 32'h00000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instruction,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             hold,
    input  logic             flush,
    output logic [31:0]      instruction_1,
    output logic [31:0]      instruction_2,
    output logic [31:0]      instruction_3,
    output logic [31:0]      instruction_4,
    output logic [3:0]       stage_valid,
    output logic             mult_ins_signal,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic [31:0]      out_instruction
);

    localparam int H = WIDTH / 2;
    localparam int P = 2 * WIDTH;

    logic [3:0]       r_valid;
    logic [31:0]      r_ins1, r_ins2, r_ins3, r_ins4;
    logic [WIDTH-1:0] r_a1, r_b1;
    logic [WIDTH-1:0] r_ll, r_lh, r_hl, r_hh;
    logic [P-1:0]     r_prod;
    logic [WIDTH-1:0] r_res;
    logic             r_ovf;

    // Operand halves: low halves unsigned, high halves carry the sign.
    logic signed [WIDTH-1:0] w_al, w_ah, w_bl, w_bh;
    logic signed [WIDTH-1:0] w_ll, w_lh, w_hl, w_hh;
    logic [P-1:0]            w_ll_x, w_lh_x, w_hl_x, w_hh_x;
    logic [P-1:0]            w_prod;
    logic [WIDTH:0]          w_top;
    logic                    w_ovf;

    assign w_al = {{H{1'b0}}, r_a1[H-1:0]};
    assign w_ah = {{H{r_a1[WIDTH-1]}}, r_a1[WIDTH-1:H]};
    assign w_bl = {{H{1'b0}}, r_b1[H-1:0]};
    assign w_bh = {{H{r_b1[WIDTH-1]}}, r_b1[WIDTH-1:H]};

    // ll may exceed the signed range but its low WIDTH bits are exact;
    // it is zero-extended below. The cross and high terms fit signed WIDTH.
    assign w_ll = w_al * w_bl;
    assign w_lh = w_ah * w_bl;
    assign w_hl = w_al * w_bh;
    assign w_hh = w_ah * w_bh;

    assign w_ll_x = {{WIDTH{1'b0}}, r_ll};
    assign w_lh_x = {{WIDTH{r_lh[WIDTH-1]}}, r_lh};
    assign w_hl_x = {{WIDTH{r_hl[WIDTH-1]}}, r_hl};
    assign w_hh_x = {{WIDTH{r_hh[WIDTH-1]}}, r_hh};

    assign w_prod = w_ll_x + (w_lh_x << H) + (w_hl_x << H) + (w_hh_x << WIDTH);

    // Fits signed WIDTH only if bits [P-1:WIDTH-1] are all equal.
    assign w_top = r_prod[P-1:WIDTH-1];
    assign w_ovf = ~(&w_top | ~|w_top);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_ins1  <= BUBBLE;
            r_ins2  <= BUBBLE;
            r_ins3  <= BUBBLE;
            r_ins4  <= BUBBLE;
            r_a1    <= '0;
            r_b1    <= '0;
            r_ll    <= '0;
            r_lh    <= '0;
            r_hl    <= '0;
            r_hh    <= '0;
            r_prod  <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_valid <= '0;
            r_ins1  <= BUBBLE;
            r_ins2  <= BUBBLE;
            r_ins3  <= BUBBLE;
            r_ins4  <= BUBBLE;
            r_a1    <= '0;
            r_b1    <= '0;
            r_ll    <= '0;
            r_lh    <= '0;
            r_hl    <= '0;
            r_hh    <= '0;
            r_prod  <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
        end else if (!hold) begin
            r_valid <= {r_valid[2:0], in_valid};
            r_ins1  <= in_valid ? in_instruction : BUBBLE;
            r_a1    <= in_valid ? in_a : '0;
            r_b1    <= in_valid ? in_b : '0;
            r_ins2  <= r_valid[0] ? r_ins1 : BUBBLE;
            r_ll    <= r_valid[0] ? w_ll : '0;
            r_lh    <= r_valid[0] ? w_lh : '0;
            r_hl    <= r_valid[0] ? w_hl : '0;
            r_hh    <= r_valid[0] ? w_hh : '0;
            r_ins3  <= r_valid[1] ? r_ins2 : BUBBLE;
            r_prod  <= r_valid[1] ? w_prod : '0;
            r_ins4  <= r_valid[2] ? r_ins3 : BUBBLE;
            r_res   <= r_valid[2] ? r_prod[WIDTH-1:0] : '0;
            r_ovf   <= r_valid[2] & w_ovf;
        end
    end

    assign instruction_1   = r_ins1;
    assign instruction_2   = r_ins2;
    assign instruction_3   = r_ins3;
    assign instruction_4   = r_ins4;
    assign stage_valid     = r_valid;
    assign mult_ins_signal = |r_valid;
    assign out_valid       = r_valid[3];
    assign out_result      = r_res;
    assign out_overflow    = r_ovf;
    assign out_instruction = r_ins4;

endmodule
